bitplane_addr_gen: RTL and testbench

//  Upstream feeder of the bitplane-to-raster stage. Walks one graphics layer's bitmap in GPU RAM in raster

---
 rtl/bitplane_addr_gen_pkg.sv | 17 +
 rtl/bitplane_addr_gen_scale_counter.sv | 30 +++
 rtl/bitplane_addr_gen.sv | 172 +++++++++++++++++
 tb/tb_bitplane_addr_gen.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/bitplane_addr_gen_pkg.sv
// Shared definitions for the bitplane address generator: colour mode codes
// and the rule deciding when the pixel counter has used up the current byte.
package bitplane_addr_gen_pkg;

  localparam logic [1:0] COLOUR_MODE_2C   = 2'd0;
  localparam logic [1:0] COLOUR_MODE_4C   = 2'd1;
  localparam logic [1:0] COLOUR_MODE_16C  = 2'd2;
  localparam logic [1:0] COLOUR_MODE_256C = 2'd3;

  // 16-colour mode holds its nibble select in x[3], so a byte covers 16 pixels;
  // every other mode advances after 8 pixels.
  function automatic logic is_byte_boundary(input logic [1:0] mode, input logic [9:0] x);
    if (mode == COLOUR_MODE_16C) return (x[3:0] == 4'hf);
    else return (x[2:0] == 3'h7);
  endfunction

endpackage

// File: rtl/bitplane_addr_gen_scale_counter.sv
// Repeat counter running 0..limit; wrap pulses combinationally on the advance
// that takes it from limit back to 0.
module bitplane_addr_gen_scale_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         en,
  input  logic         clr,
  input  logic [W-1:0] limit,
  output logic         wrap
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  assign wrap = en && (cnt_q == limit);

  always_comb begin
    cnt_d = cnt_q;
    if (clr) cnt_d = '0;
    else if (en) cnt_d = wrap ? '0 : cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

endmodule

// File: rtl/bitplane_addr_gen.sv
// Raster-order read address generator for one bitmap layer: one RAM address
// per pixel slot, with X/Y scaling and layer settings shadowed per frame.
module bitplane_addr_gen
  import bitplane_addr_gen_pkg::*;
#(
  parameter int ADDR_W  = 20,
  parameter int SCALE_W = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [3:0]        pc_ena,
  input  logic              hde,
  input  logic              vde,
  input  logic              layer_ena,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [15:0]       bytes_per_line,
  input  logic [1:0]        colour_mode_in,
  input  logic              two_byte_mode_in,
  input  logic [SCALE_W-1:0] x_scale,
  input  logic [SCALE_W-1:0] y_scale,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_rd_req,
  output logic [9:0]        x_out,
  output logic [1:0]        colour_mode_out,
  output logic              two_byte_out
);

  logic slot, active, blank, vblank, hde_fall;
  logic x_wrap, y_wrap;

  logic [ADDR_W-1:0]  base_s_q, base_s_d;
  logic [15:0]        bpl_s_q, bpl_s_d;
  logic [1:0]         mode_s_q, mode_s_d;
  logic               two_byte_s_q, two_byte_s_d;
  logic [SCALE_W-1:0] x_scale_s_q, x_scale_s_d;
  logic [SCALE_W-1:0] y_scale_s_q, y_scale_s_d;
  logic [ADDR_W-1:0]  line_addr_q, line_addr_d;
  logic [ADDR_W-1:0]  cur_addr_q, cur_addr_d;
  logic [9:0]         x_cnt_q, x_cnt_d;
  logic               hde_d_q, hde_d_d;
  logic [ADDR_W-1:0]  ram_addr_q, ram_addr_d;
  logic               rd_req_q, rd_req_d;
  logic [9:0]         x_out_q, x_out_d;
  logic [1:0]         mode_out_q, mode_out_d;
  logic               two_byte_out_q, two_byte_out_d;

  assign slot     = (pc_ena == 4'd0);
  assign active   = slot && hde && vde;
  assign blank    = slot && !hde;
  assign vblank   = slot && !vde;
  assign hde_fall = slot && vde && hde_d_q && !hde;

  bitplane_addr_gen_scale_counter #(.W(SCALE_W)) u_x_rep (
    .clk     (clk),
    .reset_n (reset_n),
    .en      (active),
    .clr     (blank),
    .limit   (x_scale_s_q),
    .wrap    (x_wrap)
  );

  bitplane_addr_gen_scale_counter #(.W(SCALE_W)) u_y_rep (
    .clk     (clk),
    .reset_n (reset_n),
    .en      (hde_fall),
    .clr     (vblank),
    .limit   (y_scale_s_q),
    .wrap    (y_wrap)
  );

  always_comb begin
    base_s_d       = base_s_q;
    bpl_s_d        = bpl_s_q;
    mode_s_d       = mode_s_q;
    two_byte_s_d   = two_byte_s_q;
    x_scale_s_d    = x_scale_s_q;
    y_scale_s_d    = y_scale_s_q;
    line_addr_d    = line_addr_q;
    cur_addr_d     = cur_addr_q;
    x_cnt_d        = x_cnt_q;
    hde_d_d        = hde_d_q;
    ram_addr_d     = ram_addr_q;
    rd_req_d       = rd_req_q;
    x_out_d        = x_out_q;
    mode_out_d     = mode_out_q;
    two_byte_out_d = two_byte_out_q;

    if (slot) hde_d_d = hde;

    if (vblank) begin
      base_s_d     = base_addr;
      bpl_s_d      = bytes_per_line;
      mode_s_d     = colour_mode_in;
      two_byte_s_d = two_byte_mode_in;
      x_scale_s_d  = x_scale;
      y_scale_s_d  = y_scale;
      line_addr_d  = {base_addr[ADDR_W-1:1], base_addr[0] & ~two_byte_mode_in};
    end else if (hde_fall && y_wrap) begin
      line_addr_d = line_addr_q + ADDR_W'(bpl_s_q);
    end

    if (slot && hde && !vde) rd_req_d = 1'b0;

    // Reload from the next line address so a one-slot blanking gap already
    // sees the stride applied by the hde fall in that same slot.
    if (blank) begin
      rd_req_d   = 1'b0;
      x_cnt_d    = '0;
      cur_addr_d = line_addr_d;
    end

    if (active) begin
      rd_req_d       = layer_ena;
      ram_addr_d     = {cur_addr_q[ADDR_W-1:1], cur_addr_q[0] & ~two_byte_s_q};
      x_out_d        = x_cnt_q;
      mode_out_d     = mode_s_q;
      two_byte_out_d = two_byte_s_q;
      if (x_wrap) begin
        x_cnt_d = x_cnt_q + 10'd1;
        if (is_byte_boundary(mode_s_q, x_cnt_q))
          cur_addr_d = cur_addr_q + (two_byte_s_q ? ADDR_W'(2) : ADDR_W'(1));
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      base_s_q       <= '0;
      bpl_s_q        <= '0;
      mode_s_q       <= '0;
      two_byte_s_q   <= 1'b0;
      x_scale_s_q    <= '0;
      y_scale_s_q    <= '0;
      line_addr_q    <= '0;
      cur_addr_q     <= '0;
      x_cnt_q        <= '0;
      hde_d_q        <= 1'b0;
      ram_addr_q     <= '0;
      rd_req_q       <= 1'b0;
      x_out_q        <= '0;
      mode_out_q     <= '0;
      two_byte_out_q <= 1'b0;
    end else begin
      base_s_q       <= base_s_d;
      bpl_s_q        <= bpl_s_d;
      mode_s_q       <= mode_s_d;
      two_byte_s_q   <= two_byte_s_d;
      x_scale_s_q    <= x_scale_s_d;
      y_scale_s_q    <= y_scale_s_d;
      line_addr_q    <= line_addr_d;
      cur_addr_q     <= cur_addr_d;
      x_cnt_q        <= x_cnt_d;
      hde_d_q        <= hde_d_d;
      ram_addr_q     <= ram_addr_d;
      rd_req_q       <= rd_req_d;
      x_out_q        <= x_out_d;
      mode_out_q     <= mode_out_d;
      two_byte_out_q <= two_byte_out_d;
    end
  end

  // base_s_q is kept as the frame's latched setting; line_addr carries its effect.
  logic unused_base;
  assign unused_base = ^base_s_q;

  assign ram_addr        = ram_addr_q;
  assign ram_rd_req      = rd_req_q;
  assign x_out           = x_out_q;
  assign colour_mode_out = mode_out_q;
  assign two_byte_out    = two_byte_out_q;

endmodule

// File: tb/tb_bitplane_addr_gen.sv
// Bench for bitplane_addr_gen: expected addresses come from a per-pixel
// arithmetic model (row, pixel, byte index) using settings captured at vblank.
module tb_bitplane_addr_gen;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [3:0]  pc_ena;
  logic        hde, vde, layer_ena;
  logic [19:0] base_addr;
  logic [15:0] bytes_per_line;
  logic [1:0]  colour_mode_in;
  logic        two_byte_mode_in;
  logic [3:0]  x_scale, y_scale;
  logic [19:0] ram_addr;
  logic        ram_rd_req;
  logic [9:0]  x_out;
  logic [1:0]  colour_mode_out;
  logic        two_byte_out;

  int total = 0;
  int bad   = 0;

  int f_base, f_bpl, f_mode, f_tb, f_xs, f_ys;

  always #5 clk = ~clk;

  bitplane_addr_gen #(.ADDR_W(20), .SCALE_W(4)) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .pc_ena           (pc_ena),
    .hde              (hde),
    .vde              (vde),
    .layer_ena        (layer_ena),
    .base_addr        (base_addr),
    .bytes_per_line   (bytes_per_line),
    .colour_mode_in   (colour_mode_in),
    .two_byte_mode_in (two_byte_mode_in),
    .x_scale          (x_scale),
    .y_scale          (y_scale),
    .ram_addr         (ram_addr),
    .ram_rd_req       (ram_rd_req),
    .x_out            (x_out),
    .colour_mode_out  (colour_mode_out),
    .two_byte_out     (two_byte_out)
  );

  task automatic slot(input logic h, input logic v);
    hde = h; vde = v; pc_ena = 4'd0;
    @(posedge clk); #1;
  endtask

  task automatic gap(input int n);
    for (int i = 0; i < n; i++) begin
      pc_ena = 4'($urandom_range(1, 15));
      @(posedge clk); #1;
    end
    pc_ena = 4'd0;
  endtask

  task automatic set_cfg(input int b, input int bpl, input int m, input int tb, input int xs, input int ys);
    base_addr = 20'(b); bytes_per_line = 16'(bpl); colour_mode_in = 2'(m);
    two_byte_mode_in = 1'(tb); x_scale = 4'(xs); y_scale = 4'(ys);
  endtask

  task automatic run_frame(input int lines, input int px, input int blanks, input bit rand_ena, input bit mid_change);
    logic [19:0] ea;
    int p, row, bw, step, base0;
    for (int i = 0; i < 2; i++) begin slot(0, 0); gap($urandom_range(0, 2)); end
    f_base = int'(base_addr); f_bpl = int'(bytes_per_line); f_mode = int'(colour_mode_in);
    f_tb = int'(two_byte_mode_in); f_xs = int'(x_scale); f_ys = int'(y_scale);
    slot(0, 1); gap($urandom_range(0, 2));
    for (int l = 0; l < lines; l++) begin
      for (int k = 0; k < px; k++) begin
        if (rand_ena) layer_ena = 1'($urandom_range(0, 1));
        slot(1, 1);
        p     = k / (f_xs + 1);
        row   = l / (f_ys + 1);
        bw    = (f_mode == 2) ? 16 : 8;
        step  = f_tb ? 2 : 1;
        base0 = f_tb ? (f_base & ~1) : f_base;
        ea    = 20'(base0 + row * f_bpl + (p / bw) * step);
        if (f_tb != 0) ea[0] = 1'b0;
        total++;
        if (ram_addr !== ea) begin
          bad++;
          $display("FAIL addr line=%0d slot=%0d got=%h exp=%h", l, k, ram_addr, ea);
        end
        total++;
        if (x_out !== 10'(p % 1024)) begin
          bad++;
          $display("FAIL x_out line=%0d slot=%0d got=%0d exp=%0d", l, k, x_out, p % 1024);
        end
        total++;
        if ({ram_rd_req, colour_mode_out, two_byte_out} !== {layer_ena, 2'(f_mode), 1'(f_tb)}) begin
          bad++;
          $display("FAIL ctrl line=%0d slot=%0d got=%b exp=%b", l, k,
                   {ram_rd_req, colour_mode_out, two_byte_out}, {layer_ena, 2'(f_mode), 1'(f_tb)});
        end
        if (k == 0) begin
          gap(3);
          total++;
          if (ram_addr !== ea) begin
            bad++;
            $display("FAIL hold line=%0d got=%h exp=%h", l, ram_addr, ea);
          end
        end else begin
          gap($urandom_range(0, 2));
        end
      end
      for (int b = 0; b < blanks; b++) begin
        slot(0, 1);
        total++;
        if (ram_rd_req !== 1'b0) begin
          bad++;
          $display("FAIL blank_req line=%0d got=%b exp=0", l, ram_rd_req);
        end
        gap($urandom_range(0, 2));
      end
      if (mid_change && l == 0)
        set_cfg($urandom_range(0, 20'hfffff), $urandom_range(0, 16'hffff), $urandom_range(0, 3),
                $urandom_range(0, 1), $urandom_range(0, 3), $urandom_range(0, 2));
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0; pc_ena = 4'd0; hde = 1'b1; vde = 1'b1; layer_ena = 1'b1;
    set_cfg(20'h01000, 40, 0, 0, 0, 0);
    repeat (3) @(posedge clk);
    #1;
    total++;
    if ({ram_addr, ram_rd_req, x_out, colour_mode_out, two_byte_out} !== 34'd0) begin
      bad++;
      $display("FAIL reset got addr=%h req=%b x=%0d cm=%0d tb=%b exp all 0",
               ram_addr, ram_rd_req, x_out, colour_mode_out, two_byte_out);
    end
    reset_n = 1'b1;
    hde = 1'b0;
  endtask

  task automatic test_mode0();
    layer_ena = 1'b1;
    set_cfg(20'h01000, 40, 0, 0, 0, 0);
    run_frame(2, 16, 2, 1'b0, 1'b0);
  endtask

  task automatic test_mode2();
    set_cfg(20'h01000, 64, 2, 0, 0, 0);
    run_frame(2, 32, 2, 1'b0, 1'b0);
  endtask

  task automatic test_two_byte();
    set_cfg(20'h01001, 80, 3, 1, 0, 0);
    run_frame(2, 24, 2, 1'b0, 1'b0);
  endtask

  task automatic test_scale();
    set_cfg(20'h02000, 40, 1, 0, 1, 2);
    run_frame(7, 20, 2, 1'b0, 1'b0);
  endtask

  task automatic test_shadow_and_wrap();
    set_cfg(20'hfffff, 16'hffff, 0, 0, 0, 0);
    run_frame(3, 16, 2, 1'b0, 1'b1);
    run_frame(2, 16, 2, 1'b0, 1'b0);
  endtask

  task automatic test_adjacent_edges();
    set_cfg(20'h00100, 3, 0, 0, 0, 0);
    run_frame(5, 1, 1, 1'b0, 1'b0);
    set_cfg(20'h00200, 7, 2, 1, 0, 1);
    run_frame(5, 2, 1, 1'b0, 1'b0);
  endtask

  task automatic test_layer_ena();
    set_cfg(20'h03000, 100, 1, 0, 2, 1);
    run_frame(3, 30, 2, 1'b1, 1'b0);
    layer_ena = 1'b1;
  endtask

  task automatic test_random();
    for (int n = 0; n < 6; n++) begin
      set_cfg($urandom_range(0, 20'hfffff), $urandom_range(0, 16'hffff), $urandom_range(0, 3),
              $urandom_range(0, 1), $urandom_range(0, 3), $urandom_range(0, 2));
      run_frame($urandom_range(3, 5), $urandom_range(8, 40), $urandom_range(1, 3), 1'b1, 1'(n % 2));
    end
    layer_ena = 1'b1;
  endtask

  task automatic test_reset_midline();
    set_cfg(20'h04000, 20, 0, 0, 0, 0);
    for (int i = 0; i < 2; i++) slot(0, 0);
    slot(0, 1);
    for (int i = 0; i < 5; i++) slot(1, 1);
    pc_ena = 4'd3;
    #2;
    reset_n = 1'b0;
    #1;
    total++;
    if ({ram_addr, ram_rd_req, x_out, colour_mode_out, two_byte_out} !== 34'd0) begin
      bad++;
      $display("FAIL reset_mid got addr=%h req=%b x=%0d exp all 0", ram_addr, ram_rd_req, x_out);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk); #1;
    gap(2);
    total++;
    if (ram_rd_req !== 1'b0) begin
      bad++;
      $display("FAIL reset_idle_req got=%b exp=0", ram_rd_req);
    end
    slot(0, 1);
    total++;
    if (ram_rd_req !== 1'b0) begin
      bad++;
      $display("FAIL reset_blank_req got=%b exp=0", ram_rd_req);
    end
    set_cfg(20'h05000, 48, 2, 0, 0, 1);
    run_frame(3, 20, 2, 1'b0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_mode0();
    test_mode2();
    test_two_byte();
    test_scale();
    test_shadow_and_wrap();
    test_adjacent_edges();
    test_layer_ena();
    test_random();
    test_reset_midline();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
